uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter CLOCK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter TIMEOUT_US, default 10_000, maximum inter-byte gap in microseconds before an open frame is abandoned.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset.
REQ-005 Port rx_data  input  8  byte from the upstream UART receiver.
REQ-006 Port rx_finished  input  1  receiver byte-done flag; may stay high for several cycles.
REQ-007 Port cmd  output  8  command byte of the last good frame.
REQ-008 Port payload  output  32  payload of the last good frame; first payload byte in [7:0].
REQ-009 Port len  output  3  payload length of the last good frame (0..4).
REQ-010 Port frame_valid  output  1  one-cycle pulse marking new cmd/payload/len.
REQ-011 Port err_checksum  output  1  one-cycle pulse on checksum mismatch.
REQ-012 Port err_len  output  1  one-cycle pulse on length byte > 4.
REQ-013 Port err_timeout  output  1  one-cycle pulse on inter-byte timeout.
REQ-014 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 A byte SHALL be accepted only on a cycle where rx_finished is 1 and was 0 the previous cycle; at most one byte per rising edge.
REQ-016 Frame format SHALL be: header 0xAA, cmd, len, len payload bytes, checksum = XOR of cmd, len and all payload bytes.
REQ-017 States SHALL be IDLE, CMD, LEN, DATA, CHK; IDLE->CMD on accepted 0xAA; non-0xAA bytes in IDLE are ignored with no pulse.
REQ-018 CMD->LEN on any accepted byte; LEN->DATA if 1<=len<=4, LEN->CHK if len=0, LEN->IDLE with err_len if len>4.
REQ-019 DATA->CHK after the len-th payload byte; a 0xAA inside the frame is treated as data, not a header.
REQ-020 In CHK, a matching byte SHALL pulse frame_valid and update cmd/payload/len the cycle after acceptance; a mismatch SHALL pulse err_checksum and leave outputs unchanged; both return to IDLE.
REQ-021 Unused payload bytes SHALL be zero in the updated payload.
REQ-022 cmd/payload/len SHALL hold until the next frame_valid.
REQ-023 Timeout counter SHALL clear on every accepted byte and in IDLE; when it reaches CLOCK_HZ/1_000_000*TIMEOUT_US-1 outside IDLE, err_timeout pulses and state returns to IDLE.
REQ-024 If a byte is accepted in the same cycle the timeout expires, the byte SHALL win and no err_timeout is raised.
REQ-025 At most one of frame_valid/err_checksum/err_len/err_timeout SHALL be high in any cycle.

Reset
REQ-026 While reset is 0 at a clock edge, state SHALL be IDLE, cmd/payload/len/all pulses/busy 0, timeout counter 0, edge history 1 (a held rx_finished is not taken as a new byte).
REQ-027 Reset mid-frame SHALL discard the partial frame with no error pulse.

Structure
REQ-028 Shared package: header constant 0xAA, MAX_LEN=4, state encodings.
REQ-029 One sub-module, timeout_counter (clear, enable, expire pulse), SHALL implement REQ-023.

Verification
REQ-030 Send AA 10 02 56 43 07 -> one frame_valid, cmd=0x10, len=2, payload=0x00004356.
REQ-031 Send AA 10 02 56 43 08 -> err_checksum once, cmd/payload unchanged from previous frame.
REQ-032 Send 55 00 AA 20 00 20 -> stray bytes ignored, frame_valid with cmd=0x20, len=0, payload=0.
REQ-033 Send AA 10 05 -> err_len after third byte, busy=0 next cycle.
REQ-034 Send AA 10 then idle 10 ms at 50 MHz -> err_timeout exactly once, then AA 30 01 AA 9B -> frame_valid cmd=0x30, payload=0x000000AA.
REQ-035 Reset low after AA 10 02 56, then full frame from REQ-030 -> no error pulses, correct frame_valid.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and FSM state encoding for the UART command-frame parser.
package uart_cmd_parser_pkg;

    localparam logic [7:0] HEADER  = 8'hAA;
    localparam int         MAX_LEN = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4
    } state_t;

endpackage

// File: rtl/uart_cmd_parser_timeout_counter.sv
// Inter-byte gap counter: clear dominates, counts while enabled, and pulses
// expire combinationally on the cycle the count reaches LIMIT-1, then wraps.
module timeout_counter #(
    parameter int LIMIT = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        expire = enable && !clear && (cnt_q == W'(LIMIT - 1));
        cnt_d  = cnt_q;
        if (clear || expire) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses AA/cmd/len/payload/xor-checksum frames from a UART byte stream;
// all outputs registered, results and error pulses appear one cycle after the final byte.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int TIMEOUT_US = 10_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_finished,
    output logic [7:0]  cmd,
    output logic [31:0] payload,
    output logic [2:0]  len,
    output logic        frame_valid,
    output logic        err_checksum,
    output logic        err_len,
    output logic        err_timeout,
    output logic        busy
);
    localparam int LIMIT = CLOCK_HZ / 1_000_000 * TIMEOUT_US;

    state_t      state_q, state_d;
    logic        rx_prev_q;
    logic [7:0]  cmd_q, cmd_d, wcmd_q, wcmd_d, csum_q, csum_d;
    logic [31:0] payload_q, payload_d, wbuf_q, wbuf_d;
    logic [2:0]  len_q, len_d, wlen_q, wlen_d, idx_q, idx_d;
    logic        frame_valid_d, err_checksum_d, err_len_d, err_timeout_d, busy_d;
    logic        frame_valid_q, err_checksum_q, err_len_q, err_timeout_q, busy_q;
    logic        accept, to_expire;

    // Rising edge of the done flag only; a held flag is one byte.
    assign accept = rx_finished && !rx_prev_q;

    timeout_counter #(.LIMIT(LIMIT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || (state_q == IDLE)),
        .enable (state_q != IDLE),
        .expire (to_expire)
    );

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        payload_d      = payload_q;
        len_d          = len_q;
        wcmd_d         = wcmd_q;
        wbuf_d         = wbuf_q;
        wlen_d         = wlen_q;
        idx_d          = idx_q;
        csum_d         = csum_q;
        frame_valid_d  = 1'b0;
        err_checksum_d = 1'b0;
        err_len_d      = 1'b0;
        err_timeout_d  = 1'b0;

        if (accept) begin
            case (state_q)
                IDLE: if (rx_data == HEADER) state_d = CMD;
                CMD: begin
                    wcmd_d  = rx_data;
                    csum_d  = rx_data;
                    wbuf_d  = '0;
                    idx_d   = '0;
                    state_d = LEN;
                end
                LEN: begin
                    wlen_d = rx_data[2:0];
                    csum_d = csum_q ^ rx_data;
                    if (rx_data > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else if (rx_data == 8'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    wbuf_d[{idx_q[1:0], 3'b000} +: 8] = rx_data;
                    csum_d = csum_q ^ rx_data;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q + 3'd1 == wlen_q) state_d = CHK;
                end
                CHK: begin
                    if (rx_data == csum_q) begin
                        frame_valid_d = 1'b1;
                        cmd_d         = wcmd_q;
                        payload_d     = wbuf_q;
                        len_d         = wlen_q;
                    end else begin
                        err_checksum_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (to_expire) begin
            err_timeout_d = 1'b1;
            state_d       = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            rx_prev_q      <= 1'b1;
            cmd_q          <= '0;
            payload_q      <= '0;
            len_q          <= '0;
            wcmd_q         <= '0;
            wbuf_q         <= '0;
            wlen_q         <= '0;
            idx_q          <= '0;
            csum_q         <= '0;
            frame_valid_q  <= 1'b0;
            err_checksum_q <= 1'b0;
            err_len_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_prev_q      <= rx_finished;
            cmd_q          <= cmd_d;
            payload_q      <= payload_d;
            len_q          <= len_d;
            wcmd_q         <= wcmd_d;
            wbuf_q         <= wbuf_d;
            wlen_q         <= wlen_d;
            idx_q          <= idx_d;
            csum_q         <= csum_d;
            frame_valid_q  <= frame_valid_d;
            err_checksum_q <= err_checksum_d;
            err_len_q      <= err_len_d;
            err_timeout_q  <= err_timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign cmd          = cmd_q;
    assign payload      = payload_q;
    assign len          = len_q;
    assign frame_valid  = frame_valid_q;
    assign err_checksum = err_checksum_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed frames against uart_cmd_parser; timeout scaled to 500 cycles.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_finished;
    logic [7:0]  cmd;
    logic [31:0] payload;
    logic [2:0]  len;
    logic        frame_valid, err_checksum, err_len, err_timeout, busy;

    int checks = 0;
    int errors = 0;
    int n_fv = 0, n_ck = 0, n_le = 0, n_to = 0, n_multi = 0;
    int b_fv, b_ck, b_le, b_to;

    uart_cmd_parser #(.CLOCK_HZ(50_000_000), .TIMEOUT_US(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_finished  (rx_finished),
        .cmd          (cmd),
        .payload      (payload),
        .len          (len),
        .frame_valid  (frame_valid),
        .err_checksum (err_checksum),
        .err_len      (err_len),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (frame_valid)  n_fv++;
        if (err_checksum) n_ck++;
        if (err_len)      n_le++;
        if (err_timeout)  n_to++;
        if (int'(frame_valid) + int'(err_checksum) + int'(err_len) + int'(err_timeout) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_fv = n_fv; b_ck = n_ck; b_le = n_le; b_to = n_to;
    endtask

    // Accepted on the second posedge after the call; flag held two cycles.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_finished = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rx_finished = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_seq(input logic [7:0] bytes [], input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[i]);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_counts(input string tag, input int fv, input int ck, input int le, input int to);
        check({tag, ".fv"}, 32'(n_fv - b_fv), 32'(fv));
        check({tag, ".ck"}, 32'(n_ck - b_ck), 32'(ck));
        check({tag, ".le"}, 32'(n_le - b_le), 32'(le));
        check({tag, ".to"}, 32'(n_to - b_to), 32'(to));
    endtask

    logic [7:0] seq [];

    initial begin
        reset = 1'b0; rx_data = 8'h00; rx_finished = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.cmd", 32'(cmd), 32'h0);
        check("rst.payload", payload, 32'h0);
        check("rst.len", 32'(len), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.pulses", 32'({frame_valid, err_checksum, err_len, err_timeout}), 32'h0);
        snap();
        // Flag still high after reset release must not count as a byte.
        rx_data = 8'hAA;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk); #1 rx_finished = 1'b0;
        settle();
        check("held.busy", 32'(busy), 32'h0);

        // Good frame, len 2
        snap();
        send_byte(8'hAA);
        @(negedge clk);
        check("hdr.busy", 32'(busy), 32'h1);
        seq = '{8'h10, 8'h02, 8'h56, 8'h43, 8'h07};
        send_seq(seq, 5);
        settle();
        check_counts("good", 1, 0, 0, 0);
        check("good.cmd", 32'(cmd), 32'h10);
        check("good.len", 32'(len), 32'h2);
        check("good.payload", payload, 32'h0000_4356);
        check("good.busy", 32'(busy), 32'h0);

        // Bad checksum keeps previous outputs
        snap();
        seq = '{8'hAA, 8'h10, 8'h02, 8'h56, 8'h43, 8'h08};
        send_seq(seq, 6);
        settle();
        check_counts("badck", 0, 1, 0, 0);
        check("badck.cmd", 32'(cmd), 32'h10);
        check("badck.payload", payload, 32'h0000_4356);
        check("badck.len", 32'(len), 32'h2);

        // Stray bytes then zero-length frame
        snap();
        seq = '{8'h55, 8'h00, 8'hAA, 8'h20, 8'h00, 8'h20};
        send_seq(seq, 6);
        settle();
        check_counts("len0", 1, 0, 0, 0);
        check("len0.cmd", 32'(cmd), 32'h20);
        check("len0.len", 32'(len), 32'h0);
        check("len0.payload", payload, 32'h0);

        // Length too large
        snap();
        seq = '{8'hAA, 8'h10, 8'h05};
        send_seq(seq, 3);
        check("lenerr.busy", 32'(busy), 32'h0);
        settle();
        check_counts("lenerr", 0, 0, 1, 0);
        check("lenerr.cmd", 32'(cmd), 32'h20);

        // Max length with 0xAA as payload data
        snap();
        seq = '{8'hAA, 8'h01, 8'h04, 8'hAA, 8'h11, 8'h22, 8'h33, 8'hAF};
        send_seq(seq, 8);
        settle();
        check_counts("len4", 1, 0, 0, 0);
        check("len4.payload", payload, 32'h3322_11AA);
        check("len4.len", 32'(len), 32'h4);

        // Timeout: none before the limit, exactly one after
        snap();
        seq = '{8'hAA, 8'h10};
        send_seq(seq, 2);
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("to.early", 32'(n_to - b_to), 32'h0);
        check("to.early_busy", 32'(busy), 32'h1);
        repeat (200) @(posedge clk);
        settle();
        check_counts("to", 0, 0, 0, 1);
        check("to.busy", 32'(busy), 32'h0);
        snap();
        seq = '{8'hAA, 8'h30, 8'h01, 8'hAA, 8'h9B};
        send_seq(seq, 5);
        settle();
        check_counts("after_to", 1, 0, 0, 0);
        check("after_to.cmd", 32'(cmd), 32'h30);
        check("after_to.payload", payload, 32'h0000_00AA);

        // Byte accepted on the very edge the timeout would expire
        snap();
        send_byte(8'hAA);
        send_byte(8'h10);          // accepted at edge E, returns at E+2
        repeat (496) @(posedge clk);
        send_byte(8'h00);          // accepted at E+500
        settle();
        check("tie.to", 32'(n_to - b_to), 32'h0);
        check("tie.busy", 32'(busy), 32'h1);
        send_byte(8'h10);
        settle();
        check_counts("tie", 1, 0, 0, 0);
        check("tie.cmd", 32'(cmd), 32'h10);
        check("tie.len", 32'(len), 32'h0);

        // Reset mid-frame
        snap();
        seq = '{8'hAA, 8'h10, 8'h02, 8'h56};
        send_seq(seq, 4);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("mid_rst.cmd", 32'(cmd), 32'h0);
        check("mid_rst.busy", 32'(busy), 32'h0);
        seq = '{8'hAA, 8'h10, 8'h02, 8'h56, 8'h43, 8'h07};
        send_seq(seq, 6);
        settle();
        check_counts("mid_rst", 1, 0, 0, 0);
        check("mid_rst.payload", payload, 32'h0000_4356);
        check("mid_rst.len", 32'(len), 32'h2);

        check("exclusive", 32'(n_multi), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
